// File: rtl/aes_key_expander_if.sv
// Command and round-key stream bundle between a key loader/consumer and aes_key_expander.
interface aes_key_expander_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic [1:0]       key_size;
  logic [255:0]     key;
  logic             busy;
  logic             err;
  logic             rk_valid;
  logic             rk_ready;
  logic [127:0]     rk_data;
  logic [IDX_W-1:0] rk_index;
  logic             done;

  modport master (
    output start, key_size, key, rk_ready,
    input  busy, err, rk_valid, rk_data, rk_index, done
  );

  modport slave (
    input  start, key_size, key, rk_ready,
    output busy, err, rk_valid, rk_data, rk_index, done
  );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule: one schedule word per clock,
// round keys streamed over valid/ready with backpressure.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        p = p ^ aa;
      end else begin
        p = p;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Inverse as x^254 = product of x^(2^k), k=1..7; zero maps to zero, then the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  assign out_byte = sbox_f(in_byte);
endmodule

module aes_key_expander #(
  parameter logic [2:0] SIZE_MASK = 3'b111,
  parameter int         IDX_W     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  aes_key_expander_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ksz_q, ksz_d;
  logic [255:0]     key_q, key_d;
  logic [31:0]      win_q [8];
  logic [31:0]      win_d [8];
  logic [5:0]       i_q, i_d;
  logic [2:0]       mod_q, mod_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [127:0]     rk_data_q, rk_data_d;
  logic [IDX_W-1:0] rk_index_q, rk_index_d;
  logic             rk_valid_q, rk_valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [5:0]  nk_s;
  logic [5:0]  last_s;
  logic [2:0]  nk_m1_s;
  logic [31:0] w_old_s;
  logic        start_ok_s;
  logic [31:0] sub_in_s;
  logic [31:0] sub_out_s;
  logic [31:0] word_s;
  logic        completes_s;
  logic        stall_s;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Per-size constants; w[i-Nk] sits at window slot Nk-1.
  always_comb begin
    case (ksz_q)
      2'd0: begin nk_s = 6'd4; nk_m1_s = 3'd3; last_s = 6'd43; w_old_s = win_q[3]; end
      2'd1: begin nk_s = 6'd6; nk_m1_s = 3'd5; last_s = 6'd51; w_old_s = win_q[5]; end
      default: begin nk_s = 6'd8; nk_m1_s = 3'd7; last_s = 6'd59; w_old_s = win_q[7]; end
    endcase
  end

  // Size legality against the build-time enable mask.
  always_comb begin
    case (bus.key_size)
      2'b00:   start_ok_s = SIZE_MASK[0];
      2'b01:   start_ok_s = SIZE_MASK[1];
      2'b10:   start_ok_s = SIZE_MASK[2];
      default: start_ok_s = 1'b0;
    endcase
  end

  assign sub_in_s = (mod_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  aes_sbox u_sb3 (.in_byte(sub_in_s[31:24]), .out_byte(sub_out_s[31:24]));
  aes_sbox u_sb2 (.in_byte(sub_in_s[23:16]), .out_byte(sub_out_s[23:16]));
  aes_sbox u_sb1 (.in_byte(sub_in_s[15:8]),  .out_byte(sub_out_s[15:8]));
  aes_sbox u_sb0 (.in_byte(sub_in_s[7:0]),   .out_byte(sub_out_s[7:0]));

  // Next schedule word w[i].
  always_comb begin
    if (i_q < nk_s) begin
      word_s = key_q[{~i_q[2:0], 5'd0} +: 32];
    end else if (mod_q == 3'd0) begin
      word_s = w_old_s ^ sub_out_s ^ {rcon_q, 24'h000000};
    end else if ((ksz_q == 2'd2) && (mod_q == 3'd4)) begin
      word_s = w_old_s ^ sub_out_s;
    end else begin
      word_s = w_old_s ^ win_q[0];
    end
  end

  assign completes_s = (i_q[1:0] == 2'b11);
  assign stall_s     = completes_s && rk_valid_q && !bus.rk_ready;

  // FSM, window advance and round-key output register next-state.
  always_comb begin
    state_d    = state_q;
    ksz_d      = ksz_q;
    key_d      = key_q;
    win_d      = win_q;
    i_d        = i_q;
    mod_d      = mod_q;
    rcon_d     = rcon_q;
    rk_data_d  = rk_data_q;
    rk_index_d = rk_index_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    if (rk_valid_q && bus.rk_ready) begin
      rk_valid_d = 1'b0;
    end else begin
      rk_valid_d = rk_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && start_ok_s) begin
          ksz_d   = bus.key_size;
          key_d   = bus.key;
          i_d     = 6'd0;
          mod_d   = 3'd0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          state_d = S_GEN;
        end else if (bus.start) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GEN: begin
        if (!stall_s) begin
          win_d[0] = word_s;
          for (int k = 1; k < 8; k++) begin
            win_d[k] = win_q[k-1];
          end
          i_d   = i_q + 6'd1;
          mod_d = (mod_q == nk_m1_s) ? 3'd0 : (mod_q + 3'd1);
          if ((i_q >= nk_s) && (mod_q == 3'd0)) begin
            rcon_d = xtime(rcon_q);
          end else begin
            rcon_d = rcon_q;
          end
          if (completes_s) begin
            rk_data_d  = {win_q[2], win_q[1], win_q[0], word_s};
            rk_index_d = IDX_W'(i_q[5:2]);
            rk_valid_d = 1'b1;
          end else begin
            rk_data_d = rk_data_q;
          end
          if (i_q == last_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_GEN;
          end
        end else begin
          state_d = S_GEN;
        end
      end
      S_DRAIN: begin
        if (rk_valid_q && bus.rk_ready) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ksz_q      <= 2'd0;
      key_q      <= 256'd0;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= 32'h0;
      end
      i_q        <= 6'd0;
      mod_q      <= 3'd0;
      rcon_q     <= 8'h01;
      rk_data_q  <= 128'd0;
      rk_index_q <= '0;
      rk_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ksz_q      <= ksz_d;
      key_q      <= key_d;
      win_q      <= win_d;
      i_q        <= i_d;
      mod_q      <= mod_d;
      rcon_q     <= rcon_d;
      rk_data_q  <= rk_data_d;
      rk_index_q <= rk_index_d;
      rk_valid_q <= rk_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_index = rk_index_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// Randomized bench for aes_key_expander against a FIPS-197 key-schedule model.
module tb_aes_key_expander;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  aes_key_expander_if #(.IDX_W(4)) bus ();
  aes_key_expander_if #(.IDX_W(4)) bus_m ();

  aes_key_expander #(.SIZE_MASK(3'b111), .IDX_W(4)) dut   (.clock(clock), .reset_n(reset_n), .bus(bus));
  aes_key_expander #(.SIZE_MASK(3'b001), .IDX_W(4)) dut_m (.clock(clock), .reset_n(reset_n), .bus(bus_m));

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   sbox_t [256];
  logic [31:0]  mw [60];
  int           nr;
  logic [127:0] got [15];
  logic [7:0]   rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box table from the classic generator/inverse walk.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  task automatic expand(input logic [1:0] ks, input logic [255:0] k);
    int nk;
    logic [31:0] t;
    nk = 4 + 2 * int'(ks);
    nr = nk + 6;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        mw[i] = k[255 - 32 * i -: 32];
      end else begin
        t = mw[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i / nk - 1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] exp_key(input int j);
    return {mw[4*j], mw[4*j+1], mw[4*j+2], mw[4*j+3]};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // One expansion run, scoreboarding every valid cycle against the model and
  // the expected first-valid cycle V_j = max(V_{j-1}+4, H_{j-1}+1).
  task automatic run_key(input string tag, input logic [1:0] ks, input logic [255:0] k,
                         input bit bp, input bit mid_start, input int abort_j);
    int c, exp_j, v_exp, h_last, hold;
    bit seen_done, err_seen, fresh, rdy;
    expand(ks, k);
    @(negedge clock);
    bus.start = 1'b1; bus.key_size = ks; bus.key = k; bus.rk_ready = 1'b1;
    @(posedge clock);
    c = 0;
    @(negedge clock);
    bus.start = 1'b0; bus.key = rand256(); bus.key_size = 2'($urandom_range(0, 3));
    chk_eq({tag, "_busy_start"}, 128'(bus.busy), 128'd1);
    exp_j = 0; v_exp = 4; h_last = -10; hold = 0;
    seen_done = 1'b0; err_seen = 1'b0; fresh = 1'b1;
    while (!seen_done && c < 400) begin
      if (bus.err) err_seen = 1'b1;
      if (bus.done) begin
        chk_eq({tag, "_done_cycle"}, 128'(c), 128'(h_last + 1));
        chk_eq({tag, "_busy_at_done"}, 128'(bus.busy), 128'd0);
        seen_done = 1'b1;
      end
      if (bus.rk_valid) begin
        if (exp_j > nr) begin
          chk_eq({tag, "_extra_valid"}, 128'd1, 128'd0);
        end else begin
          if (fresh) begin
            chk_eq({tag, "_valid_cycle"}, 128'(c), 128'(v_exp));
            fresh = 1'b0;
          end
          chk_eq({tag, "_rk_data"}, bus.rk_data, exp_key(exp_j));
          chk_eq({tag, "_rk_index"}, 128'(bus.rk_index), 128'(exp_j));
        end
      end
      if (!bp) rdy = 1'b1;
      else if (bus.rk_valid && exp_j == 3 && hold < 10) begin rdy = 1'b0; hold++; end
      else rdy = 1'($urandom_range(0, 1));
      bus.rk_ready = rdy;
      if (bus.rk_valid && rdy && exp_j <= nr) begin
        got[exp_j] = bus.rk_data;
        h_last = c;
        exp_j++;
        v_exp = (v_exp + 4 > c + 1) ? v_exp + 4 : c + 1;
        fresh = 1'b1;
        if (abort_j >= 0 && exp_j > abort_j) return;
      end
      if (mid_start && c == 10) begin
        bus.start = 1'b1; bus.key_size = 2'b00; bus.key = rand256();
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock);
      c++;
      @(negedge clock);
    end
    if (!seen_done) begin
      chk_eq({tag, "_timeout"}, 128'd0, 128'd1);
    end else begin
      chk_eq({tag, "_keys_seen"}, 128'(exp_j), 128'(nr + 1));
      @(posedge clock);
      @(negedge clock);
      chk_eq({tag, "_done_pulse"}, 128'(bus.done), 128'd0);
    end
    chk_eq({tag, "_no_err"}, 128'(err_seen), 128'd0);
  endtask

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic [1:0] rks;
    build_sbox();
    reset_n = 1'b0;
    bus.start = 1'b0;   bus.key_size = 2'b00;   bus.key = '0;   bus.rk_ready = 1'b0;
    bus_m.start = 1'b0; bus_m.key_size = 2'b00; bus_m.key = '0; bus_m.rk_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk_eq("rst_busy", 128'(bus.busy), 128'd0);
    chk_eq("rst_err", 128'(bus.err), 128'd0);
    chk_eq("rst_valid", 128'(bus.rk_valid), 128'd0);
    chk_eq("rst_data", bus.rk_data, 128'd0);
    chk_eq("rst_index", 128'(bus.rk_index), 128'd0);
    chk_eq("rst_done", 128'(bus.done), 128'd0);
    reset_n = 1'b1;

    // Reserved size, then a size disabled by the mask, then a legal one on the masked unit.
    @(negedge clock);
    bus.start = 1'b1; bus.key_size = 2'b11;
    @(posedge clock); #1;
    chk_eq("rej_reserved_err", 128'(bus.err), 128'd1);
    chk_eq("rej_reserved_busy", 128'(bus.busy), 128'd0);
    @(negedge clock);
    bus.start = 1'b0;
    bus_m.start = 1'b1; bus_m.key_size = 2'b10;
    @(posedge clock); #1;
    chk_eq("rej_err_pulse_end", 128'(bus.err), 128'd0);
    chk_eq("rej_mask_err", 128'(bus_m.err), 128'd1);
    chk_eq("rej_mask_busy", 128'(bus_m.busy), 128'd0);
    @(negedge clock);
    bus_m.key_size = 2'b00;
    @(posedge clock); #1;
    chk_eq("mask_ok_busy", 128'(bus_m.busy), 128'd1);
    chk_eq("mask_ok_err", 128'(bus_m.err), 128'd0);
    @(negedge clock);
    bus_m.start = 1'b0;

    run_key("aes128", 2'b00, K128, 1'b0, 1'b0, -1);
    chk_eq("kat128_rk0", got[0], K128[255:128]);
    chk_eq("kat128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk_eq("kat128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_key("aes192", 2'b01, K192, 1'b0, 1'b1, -1);
    chk_eq("kat192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

    run_key("aes256", 2'b10, K256, 1'b0, 1'b0, -1);
    chk_eq("kat256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    run_key("bp128", 2'b00, K128, 1'b1, 1'b0, -1);
    chk_eq("bp128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int r = 0; r < 4; r++) begin
      rks = 2'($urandom_range(0, 2));
      run_key("rand", rks, rand256(), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    // Asynchronous reset between edges after rk5 was accepted.
    run_key("abort128", 2'b00, K128, 1'b0, 1'b0, 5);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk_eq("arst_valid", 128'(bus.rk_valid), 128'd0);
    chk_eq("arst_busy", 128'(bus.busy), 128'd0);
    chk_eq("arst_data", bus.rk_data, 128'd0);
    chk_eq("arst_index", 128'(bus.rk_index), 128'd0);
    chk_eq("arst_done", 128'(bus.done), 128'd0);
    @(negedge clock);
    reset_n = 1'b1;
    run_key("fresh128", 2'b00, K128, 1'b0, 1'b0, -1);
    chk_eq("fresh128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk_eq("fresh128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
